// File: rtl/mem_pkg.sv
// mem_pkg: shared channel state type, default parameters and id-width helper for the memory channel arbiter
package mem_pkg;
  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_NUM_CONSUMERS = 8;
  localparam int DEF_NUM_CHANNELS = 2;
  typedef enum logic [1:0] {IDLE, READ_WAITING, WRITE_WAITING, RELAYING} chan_state_t;
  function automatic int id_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_channel_fsm.sv
// mem_channel_fsm: one memory channel; accepts a grant, runs the memory handshake and relays completion to its owner
module mem_channel_fsm
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int IW = id_bits(NUM_CONSUMERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 grant,
  input  logic                 grant_write,
  input  logic [IW-1:0]        grant_id,
  input  logic [ADDR_BITS-1:0] grant_addr,
  input  logic [DATA_BITS-1:0] grant_data,
  input  logic                 owner_valid,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  input  logic                 mem_write_ready,
  output chan_state_t          state,
  output logic [IW-1:0]        owner,
  output logic [IW-1:0]        ptr,
  output logic                 op_write,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  output logic                 relay_read,
  output logic                 relay_write,
  output logic [DATA_BITS-1:0] relay_data
);
  // channel state machine with all outputs registered so nothing combinational reaches the memory or consumers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      op_write <= 1'b0;
      mem_read_valid <= 1'b0;
      mem_read_address <= '0;
      mem_write_valid <= 1'b0;
      mem_write_address <= '0;
      mem_write_data <= '0;
      relay_read <= 1'b0;
      relay_write <= 1'b0;
      relay_data <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          owner <= grant_id;
          ptr <= (grant_id == IW'(NUM_CONSUMERS - 1)) ? '0 : grant_id + 1'b1;
          op_write <= grant_write;
          if (grant_write) begin
            mem_write_valid <= 1'b1;
            mem_write_address <= grant_addr;
            mem_write_data <= grant_data;
            state <= WRITE_WAITING;
          end else begin
            mem_read_valid <= 1'b1;
            mem_read_address <= grant_addr;
            state <= READ_WAITING;
          end
        end
        READ_WAITING: if (mem_read_ready) begin
          mem_read_valid <= 1'b0;
          relay_data <= mem_read_data;
          relay_read <= 1'b1;
          state <= RELAYING;
        end
        WRITE_WAITING: if (mem_write_ready) begin
          mem_write_valid <= 1'b0;
          relay_write <= 1'b1;
          state <= RELAYING;
        end
        RELAYING: if (!owner_valid) begin
          relay_read <= 1'b0;
          relay_write <= 1'b0;
          relay_data <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/mem_channel_arbiter.sv
// mem_channel_arbiter: round-robin mapping of consumer read/write requests onto memory channels; MEM_ARB_STALL_CNT_EN adds stall_count
module mem_channel_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
`ifdef MEM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                              stall_count
`endif
);
  localparam int IW = id_bits(NUM_CONSUMERS);
  chan_state_t                             state [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][IW-1:0]         owner, ptr, grant_id;
  logic [NUM_CHANNELS-1:0]                 op_write, owner_valid, grant, grant_write;
  logic [NUM_CHANNELS-1:0]                 relay_read, relay_write;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  relay_data, grant_data;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  grant_addr;
  logic [NUM_CONSUMERS-1:0]                held, taken;
  // consumers owned by a busy channel, and each channel's view of its owner's request line
  always_comb begin
    held = '0;
    owner_valid = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state[c] != IDLE) held[owner[c]] = 1'b1;
      owner_valid[c] = op_write[c] ? consumer_write_valid[owner[c]] : consumer_read_valid[owner[c]];
    end
  end
  // idle channels pick in channel order, each scanning round-robin from its own pointer; reads win over writes
  always_comb begin
    logic found;
    logic [IW-1:0] id;
    found = 1'b0;
    id = '0;
    taken = held;
    grant = '0;
    grant_write = '0;
    grant_id = '0;
    grant_addr = '0;
    grant_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      if (state[c] == IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          id = IW'((int'(ptr[c]) + k) % NUM_CONSUMERS);
          if (!found && !taken[id] && (consumer_read_valid[id] || consumer_write_valid[id])) begin
            found = 1'b1;
            taken[id] = 1'b1;
            grant[c] = 1'b1;
            grant_id[c] = id;
            grant_write[c] = !consumer_read_valid[id];
            grant_addr[c] = consumer_read_valid[id] ? consumer_read_address[id] : consumer_write_address[id];
            grant_data[c] = consumer_write_data[id];
          end
        end
      end
    end
  end
  genvar g;
  generate
    for (g = 0; g < NUM_CHANNELS; g++) begin : g_chan
      mem_channel_fsm #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS),
        .NUM_CONSUMERS(NUM_CONSUMERS),
        .IW(IW)
      ) u_fsm (
        .clk(clk),
        .reset(reset),
        .grant(grant[g]),
        .grant_write(grant_write[g]),
        .grant_id(grant_id[g]),
        .grant_addr(grant_addr[g]),
        .grant_data(grant_data[g]),
        .owner_valid(owner_valid[g]),
        .mem_read_ready(mem_read_ready[g]),
        .mem_read_data(mem_read_data[g]),
        .mem_write_ready(mem_write_ready[g]),
        .state(state[g]),
        .owner(owner[g]),
        .ptr(ptr[g]),
        .op_write(op_write[g]),
        .mem_read_valid(mem_read_valid[g]),
        .mem_read_address(mem_read_address[g]),
        .mem_write_valid(mem_write_valid[g]),
        .mem_write_address(mem_write_address[g]),
        .mem_write_data(mem_write_data[g]),
        .relay_read(relay_read[g]),
        .relay_write(relay_write[g]),
        .relay_data(relay_data[g])
      );
    end
  endgenerate
  // route relaying channels back to their owners; everything else reads as zero
  always_comb begin
    consumer_read_ready = '0;
    consumer_read_data = '0;
    consumer_write_ready = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (relay_read[c]) begin
        consumer_read_ready[owner[c]] = 1'b1;
        consumer_read_data[owner[c]] = relay_data[c];
      end
      if (relay_write[c]) consumer_write_ready[owner[c]] = 1'b1;
    end
  end
`ifdef MEM_ARB_STALL_CNT_EN
  // saturating count of cycles in which some request has no channel owning or granting it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_count <= '0;
    else if ((|((consumer_read_valid | consumer_write_valid) & ~taken)) && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// tb_mem_channel_arbiter: directed scenarios checked against a transaction-level model every cycle plus literal expectations
module tb_mem_channel_arbiter;
  localparam int A = 8, D = 8, NC = 8, CH = 2;
  logic clk = 1'b0, reset = 1'b0;
  logic [NC-1:0] crv, crr, cwv, cwr;
  logic [NC-1:0][A-1:0] cra, cwa;
  logic [NC-1:0][D-1:0] crd, cwd;
  logic [CH-1:0] mrv, mrr, mwv, mwr;
  logic [CH-1:0][A-1:0] mra, mwa;
  logic [CH-1:0][D-1:0] mrd, mwd;
`ifdef MEM_ARB_STALL_CNT_EN
  logic [15:0] stall_count;
`endif
  int checks = 0, failures = 0;
  int ph [CH], own [CH], mptr [CH];
  bit wr [CH];
  logic [7:0] ad [CH], wd [CH], rd [CH];

  always #5 clk = ~clk;

  mem_channel_arbiter #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(NC), .NUM_CHANNELS(CH)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa), .consumer_write_data(cwd),
    .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd), .mem_write_ready(mwr)
`ifdef MEM_ARB_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      ph[c] = 0; own[c] = 0; mptr[c] = 0; wr[c] = 0; ad[c] = 0; wd[c] = 0; rd[c] = 0;
    end
  endtask

  // one clock of the transaction model: 0 = free, 1 = waiting on memory, 2 = handing back to the consumer
  task automatic model_step();
    bit busy [NC];
    for (int i = 0; i < NC; i++) busy[i] = 0;
    if (!reset) return;
    for (int c = 0; c < CH; c++) if (ph[c] != 0) busy[own[c]] = 1;
    for (int c = 0; c < CH; c++) begin
      if (ph[c] == 0) begin
        for (int k = 0; k < NC; k++) begin
          int i;
          i = (mptr[c] + k) % NC;
          if (!busy[i] && (crv[i] || cwv[i])) begin
            busy[i] = 1; own[c] = i; wr[c] = !crv[i];
            ad[c] = crv[i] ? cra[i] : cwa[i]; wd[c] = cwd[i];
            ph[c] = 1; mptr[c] = (i + 1) % NC;
            break;
          end
        end
      end else if (ph[c] == 1) begin
        if (wr[c] ? mwr[c] : mrr[c]) begin
          if (!wr[c]) rd[c] = mrd[c];
          ph[c] = 2;
        end
      end else if (!(wr[c] ? cwv[own[c]] : crv[own[c]])) ph[c] = 0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic do_reset();
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
    mrr = '0; mwr = '0; mrd = '0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [NC-1:0] e_crr, e_cwr;
    logic [NC-1:0][D-1:0] e_crd;
    logic [CH-1:0] e_mrv, e_mwv;
    e_crr = '0; e_cwr = '0; e_crd = '0; e_mrv = '0; e_mwv = '0;
    for (int c = 0; c < CH; c++) begin
      if (ph[c] == 1) begin
        if (wr[c]) e_mwv[c] = 1'b1; else e_mrv[c] = 1'b1;
      end else if (ph[c] == 2) begin
        if (wr[c]) e_cwr[own[c]] = 1'b1;
        else begin
          e_crr[own[c]] = 1'b1;
          e_crd[own[c]] = rd[c];
        end
      end
    end
    chk("m_consumer_read_ready", 64'(crr), 64'(e_crr));
    chk("m_consumer_write_ready", 64'(cwr), 64'(e_cwr));
    chk("m_consumer_read_data", 64'(crd), 64'(e_crd));
    chk("m_mem_read_valid", 64'(mrv), 64'(e_mrv));
    chk("m_mem_write_valid", 64'(mwv), 64'(e_mwv));
    for (int c = 0; c < CH; c++) begin
      if (e_mrv[c]) chk("m_mem_read_address", 64'(mra[c]), 64'(ad[c]));
      if (e_mwv[c]) begin
        chk("m_mem_write_address", 64'(mwa[c]), 64'(ad[c]));
        chk("m_mem_write_data", 64'(mwd[c]), 64'(wd[c]));
      end
    end
  end

  initial begin
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
    mrr = '0; mwr = '0; mrd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {mrv, mwv, crr, cwr}, 64'd0);
    chk("reset_read_data", 64'(crd), 64'd0);
    do_reset();

    // single read
    crv[0] = 1'b1; cra[0] = 8'hFF;
    cyc(1);
    chk("rd_mem_valid", 64'(mrv), 64'h1);
    chk("rd_mem_addr", 64'(mra[0]), 64'hFF);
    mrr[0] = 1'b1; mrd[0] = 8'h5A;
    cyc(1);
    chk("rd_ready", 64'(crr), 64'h01);
    chk("rd_data", 64'(crd[0]), 64'h5A);
    chk("rd_mem_valid_drop", 64'(mrv), 64'h0);
    mrr = '0; crv = '0;
    cyc(1);
    chk("rd_done", 64'(crr), 64'h0);

    // concurrent read and write on two channels
    do_reset();
    crv[0] = 1'b1; cra[0] = 8'hFF;
    cwv[1] = 1'b1; cwa[1] = 8'hF0; cwd[1] = 8'hF0;
    cyc(1);
    chk("cc_mem_valids", {mrv, mwv}, 64'b0110);
    chk("cc_rd_addr", 64'(mra[0]), 64'hFF);
    chk("cc_wr_addr", 64'(mwa[1]), 64'hF0);
    chk("cc_wr_data", 64'(mwd[1]), 64'hF0);
    mrr[0] = 1'b1; mrd[0] = 8'h3C; mwr[1] = 1'b1;
    cyc(1);
    chk("cc_readies", {crr, cwr}, 64'h0102);
    chk("cc_rd_data", 64'(crd[0]), 64'h3C);
    crv = '0; cwv = '0; mrr = '0; mwr = '0;
    cyc(1);

    // oversubscription: eight readers on two channels
    do_reset();
    for (int i = 0; i < NC; i++) begin
      crv[i] = 1'b1; cra[i] = 8'(16 + i);
    end
    for (int r = 0; r < 4; r++) begin
      cyc(1);
      chk("os_mem_valid", 64'(mrv), 64'h3);
      chk("os_addr0", 64'(mra[0]), 64'(16 + 2 * r));
      chk("os_addr1", 64'(mra[1]), 64'(17 + 2 * r));
      mrr = 2'b11; mrd[0] = 8'(160 + 2 * r); mrd[1] = 8'(161 + 2 * r);
      cyc(1);
      chk("os_ready", 64'(crr), 64'(3 << (2 * r)));
      chk("os_data", 64'(crd[2 * r]), 64'(160 + 2 * r));
      mrr = '0; crv[2 * r] = 1'b0; crv[2 * r + 1] = 1'b0;
      cyc(1);
    end

    // read then write from the same consumer
    do_reset();
    crv[3] = 1'b1; cra[3] = 8'h33;
    cwv[3] = 1'b1; cwa[3] = 8'h44; cwd[3] = 8'h55;
    cyc(1);
    chk("rw_read_first", {mrv, mwv}, 64'b0100);
    chk("rw_rd_addr", 64'(mra[0]), 64'h33);
    mrr[0] = 1'b1; mrd[0] = 8'h77;
    cyc(1);
    chk("rw_rd_ready", {crr, cwr}, 64'h0800);
    chk("rw_rd_data", 64'(crd[3]), 64'h77);
    mrr = '0; crv[3] = 1'b0;
    cyc(1);
    chk("rw_gap", 64'(mwv), 64'h0);
    cyc(1);
    chk("rw_write_next", 64'(mwv), 64'h1);
    chk("rw_wr_addr", 64'(mwa[0]), 64'h44);
    chk("rw_wr_data", 64'(mwd[0]), 64'h55);
    mwr[0] = 1'b1;
    cyc(1);
    chk("rw_wr_ready", 64'(cwr), 64'h08);
    mwr = '0; cwv = '0;
    cyc(1);
    chk("rw_wr_done", 64'(cwr), 64'h0);

    // consumer holds valid after completion
    do_reset();
    crv[2] = 1'b1; cra[2] = 8'h22;
    cyc(1);
    chk("hv_addr", 64'(mra[0]), 64'h22);
    mrr[0] = 1'b1; mrd[0] = 8'h99;
    cyc(1);
    mrr = '0;
    for (int i = 0; i < 3; i++) begin
      chk("hv_ready_held", 64'(crr), 64'h04);
      chk("hv_data_held", 64'(crd[2]), 64'h99);
      if (i < 2) cyc(1);
    end
    crv[2] = 1'b0;
    cyc(1);
    chk("hv_released", 64'(crr), 64'h0);

    // reset while waiting on memory
    do_reset();
    crv[0] = 1'b1; cra[0] = 8'h12;
    cyc(1);
    chk("rs_waiting", 64'(mrv), 64'h1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rs_async_clear", {mrv, mwv, crr, cwr}, 64'd0);
    crv = '0; mrr[0] = 1'b1; mrd[0] = 8'hAA;
    cyc(1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("rs_no_completion", 64'(crr), 64'h0);
    end
    mrr = '0;
    cyc(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
